keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clocks each column is driven before it is sampled; legal range 4..65535.
REQ-002 Parameter DEBOUNCE, default 4, consecutive differing samples of a key needed to change its debounced state; legal range 1..7.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 resets the block.
REQ-005 row_in  input  4  raw keypad rows, active-low (pulled up), asynchronous to clk.
REQ-006 col_drive  output  4  column strobes, active-low, one-hot-low.
REQ-007 keypad_matrix  output  16  debounced key state, 1=pressed, bit index 4*row+col; feeds the CPU keypad_matrix input.
REQ-008 key_event  output  1  one-cycle pulse on any debounced 0->1 transition.
REQ-009 key_code  output  4  index of the key reported by the most recent key_event.

Function
REQ-010 row_in SHALL pass through a two-flop synchronizer per bit before any use.
REQ-011 Divider div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; col_idx (0..3) SHALL advance by 1, wrapping 3->0, on the edge where div_cnt=SCAN_DIV-1.
REQ-012 col_drive SHALL be registered and equal ~(1<<col_idx) at all times; exactly one bit low.
REQ-013 Sample edge: the edge where div_cnt=SCAN_DIV-1; the four synchronized rows SHALL be sampled for the current col_idx only, raw[r]=~row_sync[r].
REQ-014 Each key SHALL have a 3-bit counter cnt[k]; at a sample edge for key k: raw equal to keypad_matrix[k] -> cnt<=0; raw differs and cnt=DEBOUNCE-1 -> keypad_matrix[k]<=raw, cnt<=0; otherwise cnt<=cnt+1.
REQ-015 Keys not in the sampled column SHALL hold their state and counters.
REQ-016 keypad_matrix SHALL be registered; a change is visible the cycle after the sample edge that causes it.
REQ-017 key_event SHALL assert for exactly the one cycle after a sample edge that sets one or more keypad_matrix bits 0->1, and SHALL be 0 otherwise.
REQ-018 Simultaneous presses in one column: all bits set on the same edge, one key_event pulse, key_code = index of the lowest row.
REQ-019 key_code SHALL update only together with key_event and hold otherwise; releases (1->0) SHALL NOT pulse key_event or change key_code.
REQ-020 With DEBOUNCE=1, a single differing sample SHALL change state.
REQ-021 Latency, press to keypad_matrix: at most 2 sync cycles + (DEBOUNCE*4)*SCAN_DIV cycles + 1.

Reset
REQ-022 While reset=0, asynchronously: div_cnt=0, col_idx=0, col_drive=4'b1110, keypad_matrix=16'h0000, all cnt=0, synchronizer flops=4'b1111, key_event=0, key_code=0.
REQ-023 Reset asserted mid-debounce SHALL discard partial counts; scanning SHALL restart at column 0 on the first edge after release.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-024 No keys, reset released -> col_drive cycles 1110,1101,1011,0111 every 4 clocks, repeats; keypad_matrix stays 0; key_event never asserts.
REQ-025 Hold row1 low while col1 driven (key 5) -> keypad_matrix=16'h0020 after the 3rd col1 sample; key_event one cycle; key_code=5.
REQ-026 Key 5 pressed for only 2 col1 samples, then released -> keypad_matrix stays 0, no key_event; a later full press still needs 3 samples.
REQ-027 Rows 0 and 2 low during col3 (keys 3, 11) -> bits 3 and 11 set the same cycle (16'h0808); one key_event; key_code=3; release of both -> 0 after 3 samples, no key_event.
REQ-028 reset=0 after 2 of 3 press samples of key 5 -> outputs at reset values immediately; after release, 3 fresh col1 samples needed before bit 5 sets.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad one column at a time,
// debounces every key with its own small counter, and reports new presses
// as a one-cycle event carrying the key index.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_drive,
    output logic [15:0] keypad_matrix,
    output logic        key_event,
    output logic [3:0]  key_code
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  DEB_LAST = 3'(DEBOUNCE - 1);

    logic [3:0]        r_rowMeta;
    logic [3:0]        r_rowSync;
    logic [15:0]       r_divCnt;
    logic [1:0]        r_colIdx;
    logic [3:0]        r_colDrive;
    logic [15:0]       r_matrix;
    logic [15:0][2:0]  r_cnt;
    logic              r_keyEvent;
    logic [3:0]        r_keyCode;

    logic              w_sampleEdge;
    logic [1:0]        w_colNext;
    logic [3:0]        w_rawCol;
    logic [15:0]       w_matrixNext;
    logic [15:0][2:0]  w_cntNext;
    logic [15:0]       w_rise;
    logic              w_anyRise;
    logic [3:0]        w_riseCode;

    // The column is driven for a full divider period and sampled on its last cycle.
    assign w_sampleEdge = (r_divCnt == DIV_LAST);
    assign w_colNext    = r_colIdx + 2'd1;
    assign w_rawCol     = ~r_rowSync;

    // Two-flop synchronizer for the asynchronous rows; idle rows read as pulled up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rowMeta <= 4'b1111;
            r_rowSync <= 4'b1111;
        end else begin
            r_rowMeta <= row_in;
            r_rowSync <= r_rowMeta;
        end
    end

    // Scan divider and column strobe; the strobe moves on the sample edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_divCnt   <= '0;
            r_colIdx   <= '0;
            r_colDrive <= 4'b1110;
        end else if (w_sampleEdge) begin
            r_divCnt   <= '0;
            r_colIdx   <= w_colNext;
            r_colDrive <= ~(4'b0001 << w_colNext);
        end else begin
            r_divCnt   <= r_divCnt + 16'd1;
        end
    end

    // Per-key debounce: only the four keys of the sampled column move on a sample edge.
    always_comb begin
        w_matrixNext = r_matrix;
        w_cntNext    = r_cnt;
        if (w_sampleEdge) begin
            for (int k = 0; k < 16; k++) begin
                if (2'(k) == r_colIdx) begin
                    if (w_rawCol[k >> 2] == r_matrix[k]) begin
                        w_cntNext[k] = 3'd0;
                    end else if (r_cnt[k] == DEB_LAST) begin
                        w_matrixNext[k] = w_rawCol[k >> 2];
                        w_cntNext[k]    = 3'd0;
                    end else begin
                        w_cntNext[k] = r_cnt[k] + 3'd1;
                    end
                end
            end
        end
    end

    // New presses only; the lowest index wins when several land together.
    always_comb begin
        w_rise     = w_matrixNext & ~r_matrix;
        w_anyRise  = |w_rise;
        w_riseCode = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_rise[k]) begin
                w_riseCode = 4'(k);
            end
        end
    end

    // Debounced key state and per-key counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_matrix <= '0;
            r_cnt    <= '0;
        end else begin
            r_matrix <= w_matrixNext;
            r_cnt    <= w_cntNext;
        end
    end

    // Press event pulse; the code is held until the next press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keyEvent <= 1'b0;
            r_keyCode  <= 4'd0;
        end else begin
            r_keyEvent <= w_anyRise;
            if (w_anyRise) begin
                r_keyCode <= w_riseCode;
            end
        end
    end

    assign col_drive     = r_colDrive;
    assign keypad_matrix = r_matrix;
    assign key_event     = r_keyEvent;
    assign key_code      = r_keyCode;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios against a simple keypad model that
// pulls a row low whenever a pressed key sits in the driven column.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] tbKeys = 16'h0000;

    logic [3:0]  rowIn;
    logic [3:0]  colDrive;
    logic [15:0] matrix;
    logic        keyEvent;
    logic [3:0]  keyCode;

    logic [3:0]  rowIn1;
    logic [3:0]  colDrive1;
    logic [15:0] matrix1;
    logic        keyEvent1;
    logic [3:0]  keyCode1;

    int checkCount = 0;
    int errorCount = 0;
    int eventCount = 0;
    int event1Count = 0;
    int edgeNum = 0;
    int eventBase = 0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Keypad model: row r goes low if any pressed key in row r has its column driven low.
    function automatic logic [3:0] keypadRows(input logic [15:0] keys, input logic [3:0] cols);
        logic [3:0] rows;
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r + c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
        return rows;
    endfunction

    assign rowIn  = keypadRows(tbKeys, colDrive);
    assign rowIn1 = keypadRows(tbKeys, colDrive1);

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .row_in        (rowIn),
        .col_drive     (colDrive),
        .keypad_matrix (matrix),
        .key_event     (keyEvent),
        .key_code      (keyCode)
    );

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .row_in        (rowIn1),
        .col_drive     (colDrive1),
        .keypad_matrix (matrix1),
        .key_event     (keyEvent1),
        .key_code      (keyCode1)
    );

    // Count event pulses away from the active edge.
    always @(negedge clk) begin
        if (keyEvent)  eventCount  = eventCount + 1;
        if (keyEvent1) event1Count = event1Count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        tbKeys = keys;
    endtask

    // Advance to the given edge count since the last reset release, then settle.
    task automatic stepTo(input int target);
        while (edgeNum < target) begin
            @(posedge clk);
            edgeNum = edgeNum + 1;
        end
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        edgeNum = 0;
        eventBase = eventCount;
    endtask

    initial begin
        // Reset values while reset is held.
        #12;
        checkOutput("rst_col", 32'(colDrive), 32'h0000000E);
        checkOutput("rst_matrix", 32'(matrix), 32'h00000000);
        checkOutput("rst_event", 32'(keyEvent), 32'h00000000);
        checkOutput("rst_code", 32'(keyCode), 32'h00000000);

        // Idle scan: column strobe walks every 4 clocks, nothing is reported.
        @(negedge clk);
        reset = 1'b1;
        edgeNum = 0;
        eventBase = eventCount;
        stepTo(1);  checkOutput("idle_col_e1", 32'(colDrive), 32'hE);
        stepTo(3);  checkOutput("idle_col_e3", 32'(colDrive), 32'hE);
        stepTo(4);  checkOutput("idle_col_e4", 32'(colDrive), 32'hD);
        stepTo(8);  checkOutput("idle_col_e8", 32'(colDrive), 32'hB);
        stepTo(12); checkOutput("idle_col_e12", 32'(colDrive), 32'h7);
        stepTo(16); checkOutput("idle_col_e16", 32'(colDrive), 32'hE);
        stepTo(20); checkOutput("idle_col_e20", 32'(colDrive), 32'hD);
        stepTo(64);
        checkOutput("idle_matrix", 32'(matrix), 32'h0);
        checkOutput("idle_events", 32'(eventCount - eventBase), 32'd0);

        // Key 5 held: col1 samples at edges 8, 24, 40; DEBOUNCE=1 copy sets at 8.
        applyStimulus(16'h0020);
        doReset();
        stepTo(7);  checkOutput("d1_matrix_e7", 32'(matrix1), 32'h0);
        stepTo(8);
        checkOutput("d1_matrix_e8", 32'(matrix1), 32'h20);
        checkOutput("d1_event_e8", 32'(keyEvent1), 32'h1);
        checkOutput("d1_code_e8", 32'(keyCode1), 32'h5);
        checkOutput("k5_matrix_e8", 32'(matrix), 32'h0);
        stepTo(39); checkOutput("k5_matrix_e39", 32'(matrix), 32'h0);
        stepTo(40);
        checkOutput("k5_matrix_e40", 32'(matrix), 32'h20);
        checkOutput("k5_event_e40", 32'(keyEvent), 32'h1);
        checkOutput("k5_code_e40", 32'(keyCode), 32'h5);
        stepTo(41);
        checkOutput("k5_event_e41", 32'(keyEvent), 32'h0);
        checkOutput("k5_code_e41", 32'(keyCode), 32'h5);
        checkOutput("k5_events", 32'(eventCount - eventBase), 32'd1);

        // Short press: two samples then release must not set; a new press needs three.
        applyStimulus(16'h0020);
        doReset();
        stepTo(30); applyStimulus(16'h0000);
        stepTo(56); checkOutput("short_matrix_e56", 32'(matrix), 32'h0);
        stepTo(60); applyStimulus(16'h0020);
        stepTo(88); checkOutput("short_matrix_e88", 32'(matrix), 32'h0);
        stepTo(103); checkOutput("short_matrix_e103", 32'(matrix), 32'h0);
        stepTo(104); checkOutput("short_matrix_e104", 32'(matrix), 32'h20);
        stepTo(106); checkOutput("short_events", 32'(eventCount - eventBase), 32'd1);

        // Keys 3 and 11 together in col3 (samples 16, 32, 48), then released.
        applyStimulus(16'h0808);
        doReset();
        stepTo(47); checkOutput("pair_matrix_e47", 32'(matrix), 32'h0);
        stepTo(48);
        checkOutput("pair_matrix_e48", 32'(matrix), 32'h0808);
        checkOutput("pair_event_e48", 32'(keyEvent), 32'h1);
        checkOutput("pair_code_e48", 32'(keyCode), 32'h3);
        stepTo(49); checkOutput("pair_event_e49", 32'(keyEvent), 32'h0);
        stepTo(50); applyStimulus(16'h0000);
        stepTo(95); checkOutput("pair_matrix_e95", 32'(matrix), 32'h0808);
        stepTo(96);
        checkOutput("pair_matrix_e96", 32'(matrix), 32'h0);
        checkOutput("pair_code_e96", 32'(keyCode), 32'h3);
        stepTo(98); checkOutput("pair_events", 32'(eventCount - eventBase), 32'd1);

        // Mid-debounce reset: key 3 set, key 5 has two of three samples when reset hits.
        applyStimulus(16'h0008);
        doReset();
        stepTo(48);
        checkOutput("mid_matrix_e48", 32'(matrix), 32'h0008);
        checkOutput("mid_code_e48", 32'(keyCode), 32'h3);
        stepTo(50); applyStimulus(16'h0028);
        stepTo(78);
        checkOutput("mid_col_e78", 32'(colDrive), 32'h7);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_col", 32'(colDrive), 32'hE);
        checkOutput("mid_rst_matrix", 32'(matrix), 32'h0);
        checkOutput("mid_rst_event", 32'(keyEvent), 32'h0);
        checkOutput("mid_rst_code", 32'(keyCode), 32'h0);
        applyStimulus(16'h0020);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        edgeNum = 0;
        stepTo(1);  checkOutput("mid_col_e1", 32'(colDrive), 32'hE);
        stepTo(8);  checkOutput("mid_matrix_e8", 32'(matrix), 32'h0);
        stepTo(24); checkOutput("mid_matrix_e24", 32'(matrix), 32'h0);
        stepTo(40);
        checkOutput("mid_matrix_e40", 32'(matrix), 32'h20);
        checkOutput("mid_code_e40", 32'(keyCode), 32'h5);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
